// File: rtl/mem_bus_responder.sv
// Memory-side responder for CPU bus strobes: ROM/RAM/unmapped decode, registered read data,
// RAM write commit, ROM program-load port, sticky error code and saturating access counters.
module mem_bus_responder #(
  parameter int unsigned AW     = 13,
  parameter int unsigned DW     = 8,
  parameter int unsigned ROM_AW = 10,
  parameter int unsigned RAM_AW = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              ena,
  input  logic [AW-1:0]     addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DW-1:0]     data_in,
  output logic [DW-1:0]     data_out,
  output logic              data_oe,
  input  logic              prog_we,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [DW-1:0]     prog_data,
  input  logic              err_clr,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StConflict} state_e;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrConflict = 2'b01;
  localparam logic [1:0] ErrRomWrite = 2'b10;
  localparam logic [1:0] ErrUnmapped = 2'b11;

  state_e state_q, state_d;

  logic [DW-1:0]    data_q, data_d;
  logic             oe_q, oe_d;
  logic [1:0]       err_q, err_d, new_err, err_base;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             ram_we;

  logic [DW-1:0] rom_mem [2**ROM_AW];
  logic [DW-1:0] ram_mem [2**RAM_AW];

  logic          rom_hit, ram_hit;
  logic [DW-1:0] rd_data;

  assign rom_hit = (addr[AW-1:ROM_AW] == '0);
  assign ram_hit = (addr[AW-1:AW-2] == 2'b11) && (addr[AW-3:RAM_AW] == '0);

  always_comb begin
    rd_data = '0;
    if (rom_hit) begin
      rd_data = rom_mem[addr[ROM_AW-1:0]];
    end else if (ram_hit) begin
      rd_data = ram_mem[addr[RAM_AW-1:0]];
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (!ena) begin
      state_q  <= StIdle;
      data_q   <= '0;
      oe_q     <= 1'b0;
      err_q    <= ErrNone;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      oe_q     <= oe_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Memories are not reset; an aborted access never commits.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      rom_mem[prog_addr] <= prog_data;
    end
    if (ram_we && ena) begin
      ram_mem[addr[RAM_AW-1:0]] <= data_in;
    end
  end

  always_comb begin
    state_d = StIdle;
    unique case ({rd, wr})
      2'b11:   state_d = StConflict;
      2'b10:   state_d = StRead;
      2'b01:   state_d = StWrite;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    oe_d     = 1'b0;
    new_err  = ErrNone;
    ram_we   = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    unique case (state_d)
      StRead: begin
        data_d = rd_data;
        oe_d   = 1'b1;
        if (!rom_hit && !ram_hit) new_err = ErrUnmapped;
      end
      StWrite: begin
        // A held write strobe acts only on its first sampled cycle.
        if (state_q != StWrite) begin
          if (ram_hit) begin
            ram_we = 1'b1;
            if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
          end else if (rom_hit) begin
            new_err = ErrRomWrite;
          end else begin
            new_err = ErrUnmapped;
          end
        end
      end
      StConflict: new_err = ErrConflict;
      default: ;
    endcase

    if (state_q == StRead && state_d != StRead && rd_cnt_q != '1) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end

    // A clear and a fresh error in the same cycle leaves the fresh error.
    err_base = err_clr ? ErrNone : err_q;
    err_d    = (err_base == ErrNone && new_err != ErrNone) ? new_err : err_base;
  end

  assign data_out = data_q;
  assign data_oe  = oe_q;
  assign err_code = err_q;
  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed stimulus, behavioural model checked every cycle,
// plus literal expectations that pin the model.
module tb_mem_bus_responder;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          ena = 1'b0;
  logic [12:0]   addr = '0;
  logic          rd = 1'b0, wr = 1'b0;
  logic [7:0]    data_in = '0;
  logic [7:0]    data_out;
  logic          data_oe;
  logic          prog_we = 1'b0;
  logic [9:0]    prog_addr = '0;
  logic [7:0]    prog_data = '0;
  logic          err_clr = 1'b0;
  logic [1:0]    err_code;
  logic [CW-1:0] rd_cnt, wr_cnt;

  always #5 clk = ~clk;

  mem_bus_responder #(.CNT_W(CW)) dut (
    .clk      (clk),
    .ena      (ena),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .err_clr  (err_clr),
    .err_code (err_code),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: memory images, expected outputs, kind of the previous sampled cycle
  // (0 idle, 1 read, 2 write, 3 conflict).
  logic [7:0] rom_m [1024];
  logic [7:0] ram_m [512];
  logic [7:0] e_do;
  logic       e_oe;
  logic [1:0] e_err;
  int         e_rc, e_wc, prev_kind;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("data_out", 32'(data_out), 32'(e_do));
      chk("data_oe", 32'(data_oe), 32'(e_oe));
      chk("err_code", 32'(err_code), 32'(e_err));
      chk("rd_cnt", 32'(rd_cnt), 32'(e_rc));
      chk("wr_cnt", 32'(wr_cnt), 32'(e_wc));
    end
  end

  task automatic model_step();
    int ai, k;
    bit is_rom, is_ram;
    logic [7:0] rv;
    logic [1:0] ne;
    ai     = int'(addr);
    is_rom = ai < 1024;
    is_ram = ai >= 'h1800 && ai < 'h1800 + 512;
    if (!ena) begin
      e_do = 0; e_oe = 0; e_err = 0; e_rc = 0; e_wc = 0; prev_kind = 0;
    end else begin
      k  = (rd && wr) ? 3 : rd ? 1 : wr ? 2 : 0;
      rv = is_rom ? rom_m[ai] : is_ram ? ram_m[ai - 'h1800] : 8'h00;
      ne = 0;
      if (prev_kind == 1 && k != 1 && e_rc < CMAX) e_rc++;
      case (k)
        1: begin
          e_do = rv; e_oe = 1;
          if (!is_rom && !is_ram) ne = 3;
        end
        2: begin
          e_oe = 0;
          if (prev_kind != 2) begin
            if (is_ram) begin
              ram_m[ai - 'h1800] = data_in;
              if (e_wc < CMAX) e_wc++;
            end else if (is_rom) ne = 2;
            else ne = 3;
          end
        end
        3: begin e_oe = 0; ne = 1; end
        default: e_oe = 0;
      endcase
      if (err_clr) e_err = 0;
      if (ne != 0 && e_err == 0) e_err = ne;
      prev_kind = k;
    end
    if (prog_we) rom_m[prog_addr] = prog_data;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    rd = 0; wr = 0; prog_we = 0; err_clr = 0;
  endtask

  task automatic do_idle();
    set_idle(); tick();
  endtask

  task automatic do_rd(input logic [12:0] a);
    set_idle(); rd = 1; addr = a; tick();
  endtask

  task automatic do_wr(input logic [12:0] a, input logic [7:0] d, input int n);
    set_idle(); wr = 1; addr = a; data_in = d;
    repeat (n) tick();
  endtask

  task automatic do_prog(input logic [9:0] pa, input logic [7:0] pd);
    set_idle(); prog_we = 1; prog_addr = pa; prog_data = pd; tick();
    prog_we = 0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst data_oe", 32'(data_oe), 0);
    chk("rst err", 32'(err_code), 0);
    chk("rst rd_cnt", 32'(rd_cnt), 0);
    ena = 1;

    // ROM fetch
    do_prog(10'd0, 8'hA5);
    do_prog(10'd1, 8'h3C);
    do_prog(10'd2, 8'h5A);
    do_prog(10'h3FF, 8'h81);
    do_rd(13'h0000);
    chk("rom0", 32'(data_out), 32'hA5);
    chk("rom0 oe", 32'(data_oe), 1);
    do_rd(13'h0001);
    chk("rom1", 32'(data_out), 32'h3C);
    do_idle();
    chk("rd_cnt 1", 32'(rd_cnt), 1);
    chk("hold data", 32'(data_out), 32'h3C);

    // RAM write held 3 cycles, then readback
    do_wr(13'h1805, 8'h77, 3);
    do_idle();
    chk("wr_cnt 1", 32'(wr_cnt), 1);
    do_rd(13'h1805);
    chk("ram 1805", 32'(data_out), 32'h77);
    do_idle();
    chk("err none", 32'(err_code), 0);

    // ROM write protect
    do_wr(13'h0002, 8'hFF, 1);
    do_idle();
    chk("rom wr err", 32'(err_code), 2);
    chk("rom wr cnt", 32'(wr_cnt), 1);
    do_rd(13'h0002);
    chk("rom2 kept", 32'(data_out), 32'h5A);
    set_idle(); err_clr = 1; tick();
    chk("err clr", 32'(err_code), 0);

    // Conflict, then unmapped read
    do_wr(13'h1800, 8'h11, 1);
    set_idle(); rd = 1; wr = 1; addr = 13'h1800; data_in = 8'h99; tick();
    chk("conf oe", 32'(data_oe), 0);
    chk("conf err", 32'(err_code), 1);
    do_rd(13'h0800);
    chk("unmap data", 32'(data_out), 0);
    chk("unmap err sticky", 32'(err_code), 1);
    do_rd(13'h1800);
    chk("ram 1800 kept", 32'(data_out), 32'h11);
    set_idle(); err_clr = 1; tick();

    // Region boundaries
    do_wr(13'h19FF, 8'hC3, 1);
    do_rd(13'h19FF);
    chk("ram top", 32'(data_out), 32'hC3);
    do_rd(13'h03FF);
    chk("rom top", 32'(data_out), 32'h81);
    do_rd(13'h0400);
    chk("rom+1 unmapped", 32'(data_out), 0);
    chk("rom+1 err", 32'(err_code), 3);
    set_idle(); err_clr = 1; tick();
    do_wr(13'h1A00, 8'h55, 1);
    chk("ram+1 err", 32'(err_code), 3);
    chk("ram+1 wr_cnt", 32'(wr_cnt), 3);
    // Clear and new error together: new error wins
    set_idle(); rd = 1; wr = 1; err_clr = 1; tick();
    chk("clr+new err", 32'(err_code), 1);
    set_idle(); err_clr = 1; tick();

    // Program write racing a read of the same ROM byte
    set_idle(); rd = 1; addr = 13'h0001; prog_we = 1; prog_addr = 10'd1; prog_data = 8'hEE; tick();
    chk("prog old data", 32'(data_out), 32'h3C);
    do_rd(13'h0001);
    chk("prog new data", 32'(data_out), 32'hEE);
    do_idle();

    // Reset mid-read
    do_rd(13'h0000);
    ena = 0; tick();
    chk("mid rst oe", 32'(data_oe), 0);
    chk("mid rst data", 32'(data_out), 0);
    chk("mid rst rd_cnt", 32'(rd_cnt), 0);
    chk("mid rst wr_cnt", 32'(wr_cnt), 0);
    ena = 1;
    do_rd(13'h1805);
    chk("ram retained", 32'(data_out), 32'h77);
    do_rd(13'h0000);
    chk("rom retained", 32'(data_out), 32'hA5);
    do_idle();
    chk("rd_cnt after rst", 32'(rd_cnt), 1);

    // Saturation
    repeat (17) begin
      do_rd(13'h0002);
      do_idle();
    end
    chk("rd_cnt sat", 32'(rd_cnt), 32'hF);

    do_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
